// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 key tracker: decodes make/break/E0 sequences, keeps a held-key table, emits key events.
// Optional build macro PS2_KT_REPEAT_EN: typematic repeats of held keys also produce make events.
module ps2_key_tracker #(
    parameter int NUM_SLOTS      = 4,
    parameter int PREFIX_TIMEOUT = 50000
) (
    input  logic                             CLOCK_50,
    input  logic                             reset,
    input  logic [7:0]                       rx_data,
    input  logic                             rx_valid,
    input  logic                             clear_ovf,
    output logic                             evt_valid,
    output logic [8:0]                       evt_code,
    output logic                             evt_make,
    output logic [9*NUM_SLOTS-1:0]           slot_code,
    output logic [NUM_SLOTS-1:0]             slot_valid,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   held_count,
    output logic                             ovf,
    output logic [7:0]                       last_code
);

    localparam int CW = $clog2(NUM_SLOTS + 1);
    localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [TW-1:0] CNT_MAX = TW'((PREFIX_TIMEOUT > 0) ? PREFIX_TIMEOUT - 1 : 0);
`ifdef PS2_KT_REPEAT_EN
    localparam logic REPEAT_EMIT = 1'b1;
`else
    localparam logic REPEAT_EMIT = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [TW-1:0]                 r_cnt;
    logic                          r_evt_valid;
    logic [8:0]                    r_evt_code;
    logic                          r_evt_make;
    logic [NUM_SLOTS-1:0][8:0]     r_slot_code;
    logic [NUM_SLOTS-1:0]          r_slot_valid;
    logic [CW-1:0]                 r_held;
    logic                          r_ovf;
    logic [7:0]                    r_last;

    logic                          w_timeout;
    logic                          w_evt;
    logic                          w_ext;
    logic                          w_make;
    logic                          w_ignored;
    logic [8:0]                    w_key;
    logic [NUM_SLOTS-1:0]          w_hit;
    logic                          w_any_free;
    logic [IW-1:0]                 w_free_idx;
    logic [NUM_SLOTS-1:0][8:0]     w_code_nxt;
    logic [NUM_SLOTS-1:0]          w_valid_nxt;
    logic [CW-1:0]                 w_held_nxt;
    logic                          w_ovf_set;
    logic                          w_emit;

    assign w_timeout = (PREFIX_TIMEOUT != 0) && (r_state != S_IDLE) && (r_cnt == CNT_MAX);
    assign w_ignored = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
                       (rx_data == 8'hEE) || (rx_data == 8'h00) || (rx_data == 8'hFF) ||
                       (rx_data == 8'hE1);
    assign w_key     = {w_ext, rx_data};

    // Prefix FSM next state and decoded key event
    always_comb begin
        w_state_nxt = r_state;
        w_evt       = 1'b0;
        w_ext       = 1'b0;
        w_make      = 1'b0;
        if (rx_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (rx_data == 8'hE0) begin
                        w_state_nxt = S_EXT;
                    end else if (rx_data == 8'hF0) begin
                        w_state_nxt = S_BRK;
                    end else if (w_ignored) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_evt  = 1'b1;
                        w_make = 1'b1;
                    end
                end
                S_EXT: begin
                    if (rx_data == 8'hF0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (rx_data == 8'hE0) begin
                        w_state_nxt = S_EXT;
                    end else begin
                        w_evt       = 1'b1;
                        w_ext       = 1'b1;
                        w_make      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_evt       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    w_evt       = 1'b1;
                    w_ext       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Held-key table lookup, lowest free slot search and next table contents
    always_comb begin
        w_any_free  = 1'b0;
        w_free_idx  = '0;
        w_code_nxt  = r_slot_code;
        w_valid_nxt = r_slot_valid;
        w_ovf_set   = 1'b0;
        w_emit      = 1'b0;
        w_held_nxt  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_hit[i] = r_slot_valid[i] && (r_slot_code[i] == w_key);
        end
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_slot_valid[i]) begin
                w_any_free = 1'b1;
                w_free_idx = IW'(i);
            end else begin
                w_any_free = w_any_free;
            end
        end
        if (w_evt) begin
            if (!w_make) begin
                w_valid_nxt = r_slot_valid & ~w_hit;
                w_emit      = 1'b1;
            end else if (|w_hit) begin
                w_emit = REPEAT_EMIT;
            end else if (w_any_free) begin
                w_code_nxt[w_free_idx]  = w_key;
                w_valid_nxt[w_free_idx] = 1'b1;
                w_emit                  = 1'b1;
            end else begin
                w_ovf_set = 1'b1;
                w_emit    = 1'b1;
            end
        end else begin
            w_emit = 1'b0;
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_held_nxt = w_held_nxt + CW'(w_valid_nxt[i]);
        end
    end

    // FSM state and prefix timeout counter
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (rx_valid || (r_state == S_IDLE) || w_timeout) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + TW'(1);
            end
        end
    end

    // Registered event outputs, table, overflow flag and raw byte
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_evt_valid  <= 1'b0;
            r_evt_code   <= 9'h000;
            r_evt_make   <= 1'b0;
            r_slot_code  <= '0;
            r_slot_valid <= '0;
            r_held       <= '0;
            r_ovf        <= 1'b0;
            r_last       <= 8'h00;
        end else begin
            r_evt_valid  <= w_emit;
            if (w_emit) begin
                r_evt_code <= w_key;
                r_evt_make <= w_make;
            end
            r_slot_code  <= w_code_nxt;
            r_slot_valid <= w_valid_nxt;
            r_held       <= w_held_nxt;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clear_ovf) begin
                r_ovf <= 1'b0;
            end
            if (rx_valid) begin
                r_last <= rx_data;
            end
        end
    end

    assign evt_valid  = r_evt_valid;
    assign evt_code   = r_evt_code;
    assign evt_make   = r_evt_make;
    assign slot_code  = r_slot_code;
    assign slot_valid = r_slot_valid;
    assign held_count = r_held;
    assign ovf        = r_ovf;
    assign last_code  = r_last;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed self-checking bench for ps2_key_tracker (NUM_SLOTS=4, short prefix timeout).
module tb_ps2_key_tracker;

    localparam int NS = 4;
    localparam int TO = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              clear_ovf;
    logic              evt_valid;
    logic [8:0]        evt_code;
    logic              evt_make;
    logic [9*NS-1:0]   slot_code;
    logic [NS-1:0]     slot_valid;
    logic [2:0]        held_count;
    logic              ovf;
    logic [7:0]        last_code;

    int n_run  = 0;
    int n_fail = 0;
    int n_ev;

    ps2_key_tracker #(.NUM_SLOTS(NS), .PREFIX_TIMEOUT(TO)) dut (
        .CLOCK_50(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .clear_ovf(clear_ovf), .evt_valid(evt_valid), .evt_code(evt_code),
        .evt_make(evt_make), .slot_code(slot_code), .slot_valid(slot_valid),
        .held_count(held_count), .ovf(ovf), .last_code(last_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one byte for one cycle; returns on the negedge after the capturing posedge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    function automatic logic [8:0] slot(input int i);
        return slot_code[9*i +: 9];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; clear_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_slot_valid", 32'(slot_valid), 32'h0);
        chk("rst_held", 32'(held_count), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_last", 32'(last_code), 32'h00);
        reset = 1'b0;

        send(8'h1C);
        chk("mk1c_valid", 32'(evt_valid), 32'd1);
        chk("mk1c_code", 32'(evt_code), 32'h01C);
        chk("mk1c_make", 32'(evt_make), 32'd1);
        chk("mk1c_slot0", 32'(slot(0)), 32'h01C);
        chk("mk1c_sv", 32'(slot_valid), 32'h1);
        chk("mk1c_held", 32'(held_count), 32'd1);
        chk("mk1c_last", 32'(last_code), 32'h1C);
        @(negedge clk);
        chk("evt_one_cycle", 32'(evt_valid), 32'd0);

        send(8'hF0);
        chk("f0_noevt", 32'(evt_valid), 32'd0);
        chk("f0_last", 32'(last_code), 32'hF0);
        send(8'h1C);
        chk("brk1c_valid", 32'(evt_valid), 32'd1);
        chk("brk1c_code", 32'(evt_code), 32'h01C);
        chk("brk1c_make", 32'(evt_make), 32'd0);
        chk("brk1c_sv", 32'(slot_valid), 32'h0);
        chk("brk1c_held", 32'(held_count), 32'd0);
        chk("brk1c_slot0_kept", 32'(slot(0)), 32'h01C);

        send(8'hE0); send(8'h75);
        chk("ext_mk_code", 32'(evt_code), 32'h175);
        chk("ext_mk_make", 32'(evt_make), 32'd1);
        chk("ext_mk_slot0", 32'(slot(0)), 32'h175);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("ext_brk_valid", 32'(evt_valid), 32'd1);
        chk("ext_brk_code", 32'(evt_code), 32'h175);
        chk("ext_brk_make", 32'(evt_make), 32'd0);
        chk("ext_brk_sv", 32'(slot_valid), 32'h0);
        send(8'h75);
        chk("plain75_code", 32'(evt_code), 32'h075);
        chk("plain75_make", 32'(evt_make), 32'd1);
        send(8'hF0); send(8'h75);
        chk("plain75_rel", 32'(slot_valid), 32'h0);

        send(8'hAA);
        chk("ign_aa_evt", 32'(evt_valid), 32'd0);
        chk("ign_aa_last", 32'(last_code), 32'hAA);

        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
        chk("full_held", 32'(held_count), 32'd4);
        chk("full_ovf0", 32'(ovf), 32'd0);
        chk("full_slot3", 32'(slot(3)), 32'h02B);
        send(8'h34);
        chk("ovf_evt", 32'(evt_valid), 32'd1);
        chk("ovf_code", 32'(evt_code), 32'h034);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_held", 32'(held_count), 32'd4);
        chk("ovf_sv", 32'(slot_valid), 32'hF);
        @(negedge clk);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        chk("ovf_clear", 32'(ovf), 32'd0);

        send(8'hF0); send(8'h1B);
        chk("rel1_sv", 32'(slot_valid), 32'hD);
        chk("rel1_held", 32'(held_count), 32'd3);
        send(8'h34);
        chk("reuse_slot1", 32'(slot(1)), 32'h034);
        chk("reuse_sv", 32'(slot_valid), 32'hF);
        chk("reuse_ovf", 32'(ovf), 32'd0);

        send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h23);
        send(8'hF0); send(8'h2B);
        send(8'hF0); send(8'h34);
        chk("all_rel_held", 32'(held_count), 32'd0);
        send(8'hF0); send(8'h66);
        chk("brk_unheld_evt", 32'(evt_valid), 32'd1);
        chk("brk_unheld_make", 32'(evt_make), 32'd0);

        n_ev = 0;
        for (int k = 0; k < 3; k++) begin
            send(8'h1C);
            if (evt_valid) n_ev++;
        end
`ifdef PS2_KT_REPEAT_EN
        chk("repeat_events", 32'(n_ev), 32'd3);
`else
        chk("repeat_events", 32'(n_ev), 32'd1);
`endif
        chk("repeat_sv", 32'(slot_valid), 32'h1);
        chk("repeat_slot0", 32'(slot(0)), 32'h01C);
        send(8'hF0); send(8'h1C);

        send(8'hF0);
        repeat (5) @(negedge clk);
        send(8'h1C);
        chk("short_wait_brk", 32'(evt_make), 32'd0);
        send(8'hF0);
        repeat (TO + 5) @(negedge clk);
        send(8'h1C);
        chk("timeout_evt", 32'(evt_valid), 32'd1);
        chk("timeout_make", 32'(evt_make), 32'd1);
        chk("timeout_code", 32'(evt_code), 32'h01C);
        send(8'hF0); send(8'h1C);

        send(8'hE0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_last", 32'(last_code), 32'h00);
        reset = 1'b0;
        send(8'h75);
        chk("rst2_code", 32'(evt_code), 32'h075);
        chk("rst2_make", 32'(evt_make), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
